// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Sequencing front-end for the 32x8 data memory of the 8-bit CPU. It takes one load/store
// request at a time over a valid/ready handshake. For each beat it drives the memory for a
// single ACCESS cycle, then registers the result and returns it over a second valid/ready
// handshake.
//
// Optional feature macro: LSU_BURST_EN
//   defined   - Req_len is honoured: 1-4 beats at consecutive wrapping addresses. A store
//               writes the same data to every beat (fill).
//   undefined - Req_len is ignored and every transaction is a single beat.
//
// Ports
//   Clk, Reset            clock; synchronous active-high reset
//   Req_valid/Req_ready   request handshake
//   Req_we                1 = store, 0 = load
//   Req_addr              start address
//   Req_wdata             store data
//   Req_len               beats - 1 (burst build only)
//   Rsp_valid/Rsp_ready   response handshake
//   Rsp_rdata             load data, 0 for stores
//   Rsp_last              final beat of the transaction
//   Mem_Addr/Mem_Wdata    memory address and write data; hold their value outside ACCESS
//   Mem_We                memory write strobe, one cycle per store beat
//   Mem_Rdata             memory read data, a combinational read of Mem_Addr

module mem_access_unit #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_we,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [DATA_W-1:0] Req_wdata,
    input  logic [1:0]        Req_len,
    output logic              Rsp_valid,
    input  logic              Rsp_ready,
    output logic [DATA_W-1:0] Rsp_rdata,
    output logic              Rsp_last,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    output logic              Mem_We,
    input  logic [DATA_W-1:0] Mem_Rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        beat_q, beat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        req_len_eff;
    logic              last_beat;

`ifdef LSU_BURST_EN
    assign req_len_eff = Req_len;
`else
    // Single-beat build: the length input is deliberately unused.
    logic unused_req_len;
    assign unused_req_len = ^Req_len;
    assign req_len_eff    = 2'd0;
`endif

    assign last_beat = (beat_q == len_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= 2'd0;
            beat_q  <= 2'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        beat_d  = beat_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (Req_valid) begin
                    state_d = StAccess;
                    we_d    = Req_we;
                    addr_d  = Req_addr;
                    wdata_d = Req_wdata;
                    len_d   = req_len_eff;
                    beat_d  = 2'd0;
                end
            end
            StAccess: begin
                rdata_d = we_q ? '0 : Mem_Rdata;
                state_d = StResp;
            end
            StResp: begin
                if (Rsp_ready) begin
                    if (last_beat) begin
                        state_d = StIdle;
                    end else begin
                        // Address wraps naturally at ADDR_W bits.
                        addr_d  = addr_q + ADDR_W'(1);
                        beat_d  = beat_q + 2'd1;
                        state_d = StAccess;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Req_ready is masked by Reset so it reads 0 for the whole reset cycle.
    assign Req_ready = (state_q == StIdle) && !Reset;
    assign Rsp_valid = (state_q == StResp);
    assign Rsp_last  = Rsp_valid && last_beat;
    assign Rsp_rdata = rdata_q;
    // addr_q/wdata_q only change on edges entering ACCESS, so they hold between beats.
    assign Mem_Addr  = addr_q;
    assign Mem_Wdata = wdata_q;
    assign Mem_We    = (state_q == StAccess) && we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a random and directed stimulus driver feeding a reference
// model of the memory, plus a scoreboard monitor. Follows LSU_BURST_EN like the design.

module tb_mem_access_unit;

`ifdef LSU_BURST_EN
    localparam bit Burst = 1'b1;
`else
    localparam bit Burst = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req_valid = 1'b0;
    logic       Req_ready;
    logic       Req_we = 1'b0;
    logic [4:0] Req_addr = '0;
    logic [7:0] Req_wdata = '0;
    logic [1:0] Req_len = '0;
    logic       Rsp_valid;
    logic       Rsp_ready = 1'b0;
    logic [7:0] Rsp_rdata;
    logic       Rsp_last;
    logic [4:0] Mem_Addr;
    logic [7:0] Mem_Wdata;
    logic       Mem_We;
    logic [7:0] Mem_Rdata;

    mem_access_unit #(.ADDR_W(5), .DATA_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req_valid (Req_valid),
        .Req_ready (Req_ready),
        .Req_we    (Req_we),
        .Req_addr  (Req_addr),
        .Req_wdata (Req_wdata),
        .Req_len   (Req_len),
        .Rsp_valid (Rsp_valid),
        .Rsp_ready (Rsp_ready),
        .Rsp_rdata (Rsp_rdata),
        .Rsp_last  (Rsp_last),
        .Mem_Addr  (Mem_Addr),
        .Mem_Wdata (Mem_Wdata),
        .Mem_We    (Mem_We),
        .Mem_Rdata (Mem_Rdata)
    );

    always #5 Clk = ~Clk;

    // Physical memory seen by the DUT.
    logic [7:0] tb_mem [32];
    always @(posedge Clk) begin
        if (Mem_We) tb_mem[Mem_Addr] <= Mem_Wdata;
    end
    assign Mem_Rdata = tb_mem[Mem_Addr];

    // Reference model state and scoreboard queues.
    typedef struct packed {
        logic [7:0] rdata;
        logic       last;
        logic [4:0] addr;
    } rsp_t;
    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] ref_mem [32];
    rsp_t       rsp_q [$];
    wr_t        wr_q [$];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;
    int rsp_pops = 0;
    int ready_mode = 0;  // 0 low, 1 high, 2 random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Rsp_ready driver; changes only just after a rising edge.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            case (ready_mode)
                0:       Rsp_ready = 1'b0;
                1:       Rsp_ready = 1'b1;
                default: Rsp_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake, checks writes and response stability.
    initial begin
        logic       rst_edge;
        logic       hold;
        logic [7:0] prev_rdata;
        logic       prev_last;
        rsp_t       e;
        wr_t        w;
        hold = 1'b0;
        prev_rdata = '0;
        prev_last = 1'b0;
        forever begin
            @(posedge Clk);
            rst_edge = Reset;
            @(negedge Clk);
            if (hold && !rst_edge) begin
                check("rsp_valid_held", 32'(Rsp_valid), 32'd1);
                check("rsp_rdata_stable", 32'(Rsp_rdata), 32'(prev_rdata));
                check("rsp_last_stable", 32'(Rsp_last), 32'(prev_last));
            end
            if (!Reset && Mem_We) begin
                we_cnt++;
                if (wr_q.size() == 0) begin
                    check("spurious_mem_we", 32'(Mem_We), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("mem_we_addr", 32'(Mem_Addr), 32'(w.addr));
                    check("mem_we_data", 32'(Mem_Wdata), 32'(w.data));
                end
            end
            if (!Reset && Rsp_valid && Rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 32'(Rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    rsp_pops++;
                    check("rsp_rdata", 32'(Rsp_rdata), 32'(e.rdata));
                    check("rsp_last", 32'(Rsp_last), 32'(e.last));
                    check("rsp_beat_addr", 32'(Mem_Addr), 32'(e.addr));
                end
            end
            hold = !Reset && Rsp_valid && !Rsp_ready;
            prev_rdata = Rsp_rdata;
            prev_last = Rsp_last;
        end
    end

    // Issue one request; once accepted, the model computes every beat's expected outcome.
    task automatic issue(input logic we, input logic [4:0] a, input logic [7:0] d,
                         input logic [1:0] len);
        logic       ok;
        int         beats;
        int         n;
        logic [4:0] ba;
        rsp_t       e;
        wr_t        w;
        @(posedge Clk);
        #1;
        Req_valid = 1'b1;
        Req_we    = we;
        Req_addr  = a;
        Req_wdata = d;
        Req_len   = len;
        ok = 1'b0;
        n = 0;
        while (!ok && n < 300) begin
            @(negedge Clk);
            ok = Req_ready;
            @(posedge Clk);
            n++;
        end
        if (!ok) begin
            check("req_accept_timeout", 32'(ok), 32'd1);
        end else begin
            beats = Burst ? int'(len) + 1 : 1;
            for (int i = 0; i < beats; i++) begin
                ba = a + 5'(i);
                e.addr = ba;
                e.last = (i == beats - 1);
                if (we) begin
                    ref_mem[ba] = d;
                    w.addr = ba;
                    w.data = d;
                    wr_q.push_back(w);
                    e.rdata = 8'h00;
                end else begin
                    e.rdata = ref_mem[ba];
                end
                rsp_q.push_back(e);
            end
        end
        #1;
        Req_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (rsp_q.size() != 0 && n < 600) begin
            @(negedge Clk);
            n++;
        end
        if (rsp_q.size() != 0) begin
            check("drain_timeout", 32'(rsp_q.size()), 32'd0);
            rsp_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge Clk);
        while (!Rsp_valid && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("rsp_valid_seen", 32'(Rsp_valid), 32'd1);
    endtask

    initial begin
        int we0;
        int p0;
        int n;

        // Reset held for two edges.
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_req_ready", 32'(Req_ready), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("post_reset_req_ready", 32'(Req_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(Rsp_valid), 32'd0);
        check("post_reset_rsp_rdata", 32'(Rsp_rdata), 32'd0);
        check("post_reset_rsp_last", 32'(Rsp_last), 32'd0);
        check("post_reset_mem_addr", 32'(Mem_Addr), 32'd0);
        check("post_reset_mem_wdata", 32'(Mem_Wdata), 32'd0);
        check("post_reset_mem_we", 32'(Mem_We), 32'd0);

        // Preload every location through the unit so the model knows the memory contents.
        ready_mode = 1;
        for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 8'($urandom), 2'd0);
        wait_empty();

        // Store 0xA5 to 7: exactly one write strobe.
        we0 = we_cnt;
        issue(1'b1, 5'd7, 8'hA5, 2'd0);
        wait_empty();
        check("store_we_pulses", 32'(we_cnt - we0), 32'd1);

        // Load 7: response one edge after the ACCESS cycle.
        issue(1'b0, 5'd7, 8'h00, 2'd0);
        @(negedge Clk);
        check("load_access_valid", 32'(Rsp_valid), 32'd0);
        check("load_access_addr", 32'(Mem_Addr), 32'd7);
        check("load_access_we", 32'(Mem_We), 32'd0);
        @(negedge Clk);
        check("load_rsp_valid", 32'(Rsp_valid), 32'd1);
        check("load_rsp_rdata_a5", 32'(Rsp_rdata), 32'hA5);
        wait_empty();

        // Load 3 with the response stalled for five cycles; stray requests are ignored.
        ready_mode = 0;
        issue(1'b0, 5'd3, 8'h00, 2'd0);
        wait_valid();
        Req_valid = 1'b1;
        Req_we    = 1'b1;
        Req_addr  = 5'd3;
        Req_wdata = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("stall_req_ready", 32'(Req_ready), 32'd0);
            check("stall_rsp_rdata", 32'(Rsp_rdata), 32'(ref_mem[3]));
        end
        Req_valid = 1'b0;
        ready_mode = 1;
        wait_empty();

        if (Burst) begin
            // Wrapping 4-beat load burst.
            issue(1'b1, 5'd30, 8'h11, 2'd0);
            issue(1'b1, 5'd31, 8'h22, 2'd0);
            issue(1'b1, 5'd0, 8'h33, 2'd0);
            issue(1'b1, 5'd1, 8'h44, 2'd0);
            issue(1'b0, 5'd30, 8'h00, 2'd3);
            wait_empty();
            // Fill store over 10..12; 13 untouched.
            issue(1'b1, 5'd10, 8'h5A, 2'd2);
            for (int i = 10; i < 14; i++) issue(1'b0, 5'(i), 8'h00, 2'd0);
            wait_empty();
        end

        // Reset while a response is pending (beat 2 of a 4-beat burst in the burst build).
        p0 = rsp_pops;
        if (!Burst) ready_mode = 0;
        issue(1'b0, 5'd20, 8'h00, 2'd3);
        if (Burst) begin
            n = 0;
            while (rsp_pops == p0 && n < 50) begin
                @(negedge Clk);
                n++;
            end
            ready_mode = 0;
        end
        wait_valid();
        #2;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        rsp_q.delete();
        @(negedge Clk);
        check("midreset_rsp_valid", 32'(Rsp_valid), 32'd0);
        check("midreset_req_ready", 32'(Req_ready), 32'd1);
        check("midreset_mem_we", 32'(Mem_We), 32'd0);
        repeat (4) @(negedge Clk);
        ready_mode = 1;

        // Random traffic with random response back-pressure.
        ready_mode = 2;
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 2'($urandom));
        end
        wait_empty();
        repeat (3) @(negedge Clk);
        check("pending_writes", 32'(wr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencing front-end for the 32×8 data memory of the 8-bit CPU. It accepts load/store requests from the core's execute stage over a valid/ready handshake and drives the memory's address, write-data and write-enable lines for exactly one cycle per beat. It captures read data into a registered response and returns it over a second valid/ready handshake. It sits directly upstream of the data memory, which is the only consumer of its Mem_* outputs.

## Interface
- ADDR_W, 5: memory address width; 32 locations.
- DATA_W, 8: data width.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req_valid  in  1  request present.
- Req_ready  out  1  unit can accept a request.
- Req_we  in  1  1 = store, 0 = load.
- Req_addr  in  ADDR_W  start address.
- Req_wdata  in  DATA_W  store data.
- Req_len  in  2  beats − 1; used only with LSU_BURST_EN.
- Rsp_valid  out  1  response present.
- Rsp_ready  in  1  core accepts the response.
- Rsp_rdata  out  DATA_W  load data; 0 for stores.
- Rsp_last  out  1  final beat of the transaction.
- Mem_Addr  out  ADDR_W  to memory Address.
- Mem_Wdata  out  DATA_W  to memory Data_in.
- Mem_We  out  1  to memory En; write strobe.
- Mem_Rdata  in  DATA_W  from memory Data_out; combinational read of Mem_Addr.

## Operation
- FSM states:
  - IDLE: Req_ready = 1. On Req_valid & Req_ready, latch we, addr, wdata and len, set beat count to 0, and go to ACCESS.
  - ACCESS (one cycle): Mem_Addr = current address; Mem_Wdata = latched wdata; Mem_We = latched we. At the end of the cycle, a load captures Mem_Rdata into Rsp_rdata and a store sets Rsp_rdata = 0. Go to RESP.
  - RESP: Rsp_valid = 1 and Rsp_last = (beat == len). Hold Rsp_rdata and Rsp_last stable until Rsp_ready. On Rsp_ready:
    - if last, go to IDLE;
    - otherwise increment the address modulo 32 and the beat count, then go to ACCESS.
- Mem_We is 0 in every state except ACCESS with a store. Mem_Addr and Mem_Wdata hold their last driven values outside ACCESS.
- Address arithmetic is ADDR_W bits, unsigned, with wrap 31 → 0. The beat counter is 2 bits.
- Req_* inputs are ignored outside IDLE. Response ordering is strictly in issue order.
- Rsp_valid never drops without Rsp_ready, and Rsp_rdata never changes while Rsp_valid is high.

## Timing
- Reset values: state IDLE, Req_ready 0 while Reset is high and 1 from the first cycle after, Rsp_valid 0, Rsp_rdata 0, Rsp_last 0, Mem_Addr 0, Mem_Wdata 0, Mem_We 0.
- Request accepted at edge N → ACCESS during cycle N..N+1 → Rsp_valid = 1 after edge N+1.
- Single-beat throughput with Rsp_ready tied high: one transaction per 3 cycles (IDLE, ACCESS, RESP).
- Burst beat spacing is 2 cycles per beat when Rsp_ready is high.
- A store is visible to a load accepted in any later IDLE; no forwarding is needed.
- Reset mid-operation: the next edge forces IDLE, clears Rsp_valid and Mem_We, and discards the remaining beats. The in-flight ACCESS write outcome is governed by the memory's own reset.
- Rsp_ready high while Rsp_valid is low has no effect.

## Configuration
- LSU_BURST_EN defined: Req_len is honoured, giving 1–4 beats at consecutive wrapping addresses.
  - Loads return one response per beat.
  - Stores write the same latched Req_wdata to every beat (fill) and return one response per beat with Rsp_rdata = 0.
- LSU_BURST_EN undefined: Req_len is ignored and treated as 0, every transaction is single-beat, and Rsp_last = Rsp_valid.
- The port list is identical in both builds.

## Test plan
- Reset held 2 cycles, then released → all outputs at their reset values; Req_ready = 1 on the first cycle after release.
- Store 0xA5 to address 7, then load address 7 with Rsp_ready = 1 → Mem_We high for exactly one cycle with Mem_Addr = 7; load response Rsp_rdata = 0xA5, Rsp_last = 1, Rsp_valid 1 after edge N+1.
- Load address 3 with Rsp_ready held low for 5 cycles → Rsp_valid and Rsp_rdata stable for all 5 cycles; Req_ready = 0 throughout; Req_valid pulses are ignored.
- LSU_BURST_EN: preload addresses 30, 31, 0, 1 with 0x11, 0x22, 0x33, 0x44; load addr 30 len 3 → four responses 0x11, 0x22, 0x33, 0x44 with Rsp_last only on the fourth; Mem_Addr sequence 30, 31, 0, 1.
- LSU_BURST_EN: fill store 0x5A at addr 10 len 2 → locations 10–12 read back 0x5A and location 13 is unchanged.
- Reset asserted during RESP of beat 2 of a 4-beat burst → next cycle Rsp_valid = 0 and the state is IDLE; Mem_We is never asserted again before a new request.
